jt12_mixer: RTL and testbench
=============================

Name: jt12_mixer

Overview:
- Parametrised successor to the fixed 6-channel OPN2 output stage.
- Takes the time-multiplexed operator result stream, sums carrier slots per frame into stereo sums, and handles PCM substitution on the last channel.
- Applies optional saturation limiting, then emits one combined stereo sample per frame plus a serialised per-channel multiplexed output.
- Sits between the operator pipeline and the board-level audio DAC/resampler.

Parameters:
- CHANNELS, 6, number of FM channels in a frame (2..16).
- OPW, 9, width of signed operator result and PCM sample.
- OUTW, 12, width of signed combined outputs (OUTW > OPW).
- CHW, 3, width of channel index (2^CHW >= CHANNELS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cen  in  1  clock enable; all state advances only when cen=1
- zero  in  1  marks first slot of a new frame (qualified by cen)
- op_result  in  OPW  signed operator output for current slot
- op_valid  in  1  current slot is a carrier and contributes to output
- ch  in  CHW  channel index of current slot
- rl  in  2  pan of current slot's channel: [1]=left enable, [0]=right enable
- pcm_en  in  1  replace channel CHANNELS-1 with PCM
- pcm  in  OPW  signed PCM sample
- limiter_en  in  1  1=saturate outputs, 0=wrap (truncate)
- left  out  OUTW  signed combined left sample
- right  out  OUTW  signed combined right sample
- sample  out  1  one-cycle pulse when left/right update
- clip  out  1  latched with sample: the last frame saturated or wrapped on either side
- mux_left  out  OPW  signed per-channel left value
- mux_right  out  OPW  signed per-channel right value
- mux_ch  out  CHW  channel index of current mux values
- mux_sample  out  1  one-cycle pulse per mux value

Behaviour:
- Reset (rst_n=0, asynchronous): all accumulators, per-channel sums, stored pan bits, outputs, pulses and mux counter = 0. mux is idle.
- Accumulator width: ACCW = OPW + clog2(4*CHANNELS) + 1. All sums are sign-extended; there is no internal overflow.
- Contribution per slot (cen=1):
  - c = op_result if op_valid.
  - Slots with ch=CHANNELS-1 are dropped when pcm_en=1.
  - Slots with ch >= CHANNELS are always dropped.
  - c goes to the left sum if rl[1], and to the right sum if rl[0].
  - rl is stored per channel on every valid slot.
- Frame boundary (cen & zero):
  - Previous-frame acc_l/acc_r are converted to OUTW and registered on left/right. sample=1 for that cycle.
  - The accumulators then load the current slot's contribution, plus PCM if pcm_en (pcm sign-extended, added to both sides gated by the stored rl of channel CHANNELS-1).
  - The zero slot always belongs to the new frame.
- Non-boundary (cen & !zero): acc += contribution.
- cen=0: no state change. sample and mux_sample are forced 0.
- Conversion:
  - limiter_en=1: clamp to [-2^(OUTW-1), 2^(OUTW-1)-1].
  - limiter_en=0: take the OUTW LSBs.
  - clip=1 if the value was out of range on either side.
  - limiter_en is sampled at the boundary cycle.
- Per-channel sums ch_sum[k] (OPW+3 bits, separate left/right, PCM included as for the combined path) accumulate in parallel. They are snapshotted to a shadow bank at the boundary and cleared or reloaded as above.
- Mux FSM:
  - States IDLE and SHIFT.
  - On boundary: go to SHIFT with k=0.
  - In SHIFT, each cen cycle: output shadow[k] converted to OPW (same limiter rule), mux_ch=k, mux_sample=1, then k++.
  - After k=CHANNELS-1: go to IDLE.
  - A boundary arriving while in SHIFT restarts at k=0 with the new shadow bank; the remaining old values are discarded.
- Latency: left/right and sample appear the cycle after the boundary edge. The first mux value appears on the next cen cycle after that.
- Outputs hold between updates.
- Reset mid-frame discards the partial frame. The first boundary after reset outputs only the sums accumulated since reset.

Test Plan:
- Reset, then 24-slot frame (cen=1) with ch0 carrier op_result=+100, rl=11, next zero -> left=right=100, sample single pulse, clip=0; mux_ch=0 gives mux_left=100, then ch1..5 give 0.
- All 6 channels: 4 carrier slots each at +255, rl=11, limiter_en=1 -> sum 6120 clamps to left=2047, clip=1. Same with limiter_en=0 -> left = 6120 mod 4096 as signed = 2024, clip=1.
- Pan: ch1 rl=10 value -50, ch2 rl=01 value +30 -> left=-50, right=30.
- pcm_en=1, pcm=-200, ch5 carriers at +100, rl[ch5]=11 -> ch5 dropped; left=right=-200; mux ch5 = -200 saturated to -200.
- op_valid and zero in the same cycle with +7, all other slots silent -> value appears in the following frame's output, not the current one.
- cen toggling 1/0, plus zero asserted in the middle of mux SHIFT at k=3 -> no updates in cen=0 cycles; mux restarts at k=0; rst_n pulse mid-frame clears all outputs asynchronously.

Source files
------------

// File: rtl/jt12_mixer.sv
`default_nettype none
// =============================================================================
// jt12_mixer : frame mixer for the time-multiplexed operator result stream.
//   Sums carrier slots into stereo frame sums and per-channel sums, substitutes
//   PCM on the last channel, then saturates or wraps the results onto a combined
//   stereo output and a serial per-channel output.
// Revision 1.0
// =============================================================================
module jt12_mixer #(
   parameter int CHANNELS = 6,
   parameter int OPW      = 9,
   parameter int OUTW     = 12,
   parameter int CHW      = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic            zero,
   input  logic [OPW-1:0]  op_result,
   input  logic            op_valid,
   input  logic [CHW-1:0]  ch,
   input  logic [1:0]      rl,
   input  logic            pcm_en,
   input  logic [OPW-1:0]  pcm,
   input  logic            limiter_en,
   output logic [OUTW-1:0] left,
   output logic [OUTW-1:0] right,
   output logic            sample,
   output logic            clip,
   output logic [OPW-1:0]  mux_left,
   output logic [OPW-1:0]  mux_right,
   output logic [CHW-1:0]  mux_ch,
   output logic            mux_sample
);

   localparam int ACCW = OPW + $clog2(4*CHANNELS) + 1;
   localparam int CSW  = OPW + 3;

   localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS-1);
   localparam logic [CHW:0]   NUM_CH  = (CHW+1)'(CHANNELS);

   localparam logic signed [ACCW-1:0] OUT_MAX = ACCW'((2**(OUTW-1)) - 1);
   localparam logic signed [ACCW-1:0] OUT_MIN = ACCW'(-(2**(OUTW-1)));
   localparam logic signed [CSW-1:0]  MUX_MAX = CSW'((2**(OPW-1)) - 1);
   localparam logic signed [CSW-1:0]  MUX_MIN = CSW'(-(2**(OPW-1)));

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   function automatic logic ovf_out(input logic signed [ACCW-1:0] v);
      return (v > OUT_MAX) || (v < OUT_MIN);
   endfunction

   function automatic logic [OUTW-1:0] conv_out(input logic signed [ACCW-1:0] v,
                                                input logic lim);
      logic [OUTW-1:0] r;
      r = v[OUTW-1:0];
      if (lim && (v > OUT_MAX))      r = OUT_MAX[OUTW-1:0];
      else if (lim && (v < OUT_MIN)) r = OUT_MIN[OUTW-1:0];
      return r;
   endfunction

   function automatic logic [OPW-1:0] conv_mux(input logic signed [CSW-1:0] v,
                                               input logic lim);
      logic [OPW-1:0] r;
      r = v[OPW-1:0];
      if (lim && (v > MUX_MAX))      r = MUX_MAX[OPW-1:0];
      else if (lim && (v < MUX_MIN)) r = MUX_MIN[OPW-1:0];
      return r;
   endfunction

   // ---------------------------------------------------------------- slot decode
   logic                   w_bnd;
   logic                   w_keep;
   logic                   w_pcm_l;
   logic                   w_pcm_r;
   logic signed [ACCW-1:0] w_op_a;
   logic signed [ACCW-1:0] w_pcm_a;
   logic signed [CSW-1:0]  w_op_c;
   logic signed [CSW-1:0]  w_pcm_c;
   logic signed [ACCW-1:0] w_add_l;
   logic signed [ACCW-1:0] w_add_r;
   logic signed [ACCW-1:0] w_base_l;
   logic signed [ACCW-1:0] w_base_r;

   logic [1:0] rl_q [CHANNELS];
   logic [1:0] rl_d [CHANNELS];

   assign w_bnd  = cen & zero;
   // The last channel is silenced while PCM owns it; out-of-range slots never count.
   assign w_keep = op_valid & ({1'b0, ch} < NUM_CH) & ~(pcm_en & (ch == LAST_CH));

   assign w_op_a  = {{(ACCW-OPW){op_result[OPW-1]}}, op_result};
   assign w_pcm_a = {{(ACCW-OPW){pcm[OPW-1]}}, pcm};
   assign w_op_c  = {{(CSW-OPW){op_result[OPW-1]}}, op_result};
   assign w_pcm_c = {{(CSW-OPW){pcm[OPW-1]}}, pcm};

   assign w_pcm_l = w_bnd & pcm_en & rl_q[CHANNELS-1][1];
   assign w_pcm_r = w_bnd & pcm_en & rl_q[CHANNELS-1][0];

   assign w_add_l = (w_keep & rl[1]) ? w_op_a : '0;
   assign w_add_r = (w_keep & rl[0]) ? w_op_a : '0;

   // ---------------------------------------------------------------- combined path
   logic signed [ACCW-1:0] acc_l_q, acc_l_d;
   logic signed [ACCW-1:0] acc_r_q, acc_r_d;
   logic [OUTW-1:0]        left_q, left_d;
   logic [OUTW-1:0]        right_q, right_d;
   logic                   clip_q, clip_d;
   logic                   sample_q, sample_d;
   logic                   lim_q, lim_d;

   assign w_base_l = w_bnd ? (w_pcm_l ? w_pcm_a : '0) : acc_l_q;
   assign w_base_r = w_bnd ? (w_pcm_r ? w_pcm_a : '0) : acc_r_q;

   always_comb begin
      acc_l_d  = acc_l_q;
      acc_r_d  = acc_r_q;
      left_d   = left_q;
      right_d  = right_q;
      clip_d   = clip_q;
      lim_d    = lim_q;
      sample_d = w_bnd;
      if (cen) begin
         acc_l_d = w_base_l + w_add_l;
         acc_r_d = w_base_r + w_add_r;
      end
      if (w_bnd) begin
         left_d  = conv_out(acc_l_q, limiter_en);
         right_d = conv_out(acc_r_q, limiter_en);
         clip_d  = ovf_out(acc_l_q) | ovf_out(acc_r_q);
         lim_d   = limiter_en;
      end
   end

   // ---------------------------------------------------------------- per-channel path
   logic signed [CSW-1:0] chl_q [CHANNELS];
   logic signed [CSW-1:0] chl_d [CHANNELS];
   logic signed [CSW-1:0] chr_q [CHANNELS];
   logic signed [CSW-1:0] chr_d [CHANNELS];
   logic signed [CSW-1:0] shl_q [CHANNELS];
   logic signed [CSW-1:0] shl_d [CHANNELS];
   logic signed [CSW-1:0] shr_q [CHANNELS];
   logic signed [CSW-1:0] shr_d [CHANNELS];

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         chl_d[k] = chl_q[k];
         chr_d[k] = chr_q[k];
         shl_d[k] = shl_q[k];
         shr_d[k] = shr_q[k];
         rl_d[k]  = rl_q[k];
         if (cen) begin
            if (w_bnd) begin
               shl_d[k] = chl_q[k];
               shr_d[k] = chr_q[k];
               chl_d[k] = '0;
               chr_d[k] = '0;
            end
            if (w_keep && (ch == CHW'(k))) begin
               if (rl[1]) chl_d[k] = chl_d[k] + w_op_c;
               if (rl[0]) chr_d[k] = chr_d[k] + w_op_c;
            end
            if (op_valid && (ch == CHW'(k))) rl_d[k] = rl;
         end
      end
      if (w_pcm_l) chl_d[CHANNELS-1] = chl_d[CHANNELS-1] + w_pcm_c;
      if (w_pcm_r) chr_d[CHANNELS-1] = chr_d[CHANNELS-1] + w_pcm_c;
   end

   // ---------------------------------------------------------------- mux serialiser
   state_t         state_q, state_d;
   logic [CHW-1:0] k_q, k_d;
   logic [OPW-1:0] mux_l_q, mux_l_d;
   logic [OPW-1:0] mux_r_q, mux_r_d;
   logic [CHW-1:0] mux_ch_q, mux_ch_d;
   logic           mux_smp_q, mux_smp_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A new boundary always wins: the remaining old shadow values are dropped.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      mux_l_d   = mux_l_q;
      mux_r_d   = mux_r_q;
      mux_ch_d  = mux_ch_q;
      mux_smp_d = 1'b0;
      if (cen) begin
         if (zero) begin
            state_d = SHIFT;
            k_d     = '0;
         end else if (state_q == SHIFT) begin
            mux_l_d   = conv_mux(shl_q[k_q], lim_q);
            mux_r_d   = conv_mux(shr_q[k_q], lim_q);
            mux_ch_d  = k_q;
            mux_smp_d = 1'b1;
            if (k_q == LAST_CH) begin
               state_d = IDLE;
               k_d     = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_l_q   <= '0;
         acc_r_q   <= '0;
         left_q    <= '0;
         right_q   <= '0;
         clip_q    <= 1'b0;
         sample_q  <= 1'b0;
         lim_q     <= 1'b0;
         k_q       <= '0;
         mux_l_q   <= '0;
         mux_r_q   <= '0;
         mux_ch_q  <= '0;
         mux_smp_q <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            chl_q[k] <= '0;
            chr_q[k] <= '0;
            shl_q[k] <= '0;
            shr_q[k] <= '0;
            rl_q[k]  <= '0;
         end
      end else begin
         acc_l_q   <= acc_l_d;
         acc_r_q   <= acc_r_d;
         left_q    <= left_d;
         right_q   <= right_d;
         clip_q    <= clip_d;
         sample_q  <= sample_d;
         lim_q     <= lim_d;
         k_q       <= k_d;
         mux_l_q   <= mux_l_d;
         mux_r_q   <= mux_r_d;
         mux_ch_q  <= mux_ch_d;
         mux_smp_q <= mux_smp_d;
         chl_q     <= chl_d;
         chr_q     <= chr_d;
         shl_q     <= shl_d;
         shr_q     <= shr_d;
         rl_q      <= rl_d;
      end
   end

   assign left       = left_q;
   assign right      = right_q;
   assign sample     = sample_q;
   assign clip       = clip_q;
   assign mux_left   = mux_l_q;
   assign mux_right  = mux_r_q;
   assign mux_ch     = mux_ch_q;
   assign mux_sample = mux_smp_q;

endmodule
`default_nettype wire

// File: tb/tb_jt12_mixer.sv
`default_nettype none
// =============================================================================
// tb_jt12_mixer : directed and randomized frames against a frame-level model.
// Revision 1.0
// =============================================================================
module tb_jt12_mixer;

   localparam int CHANNELS = 6;
   localparam int OPW      = 9;
   localparam int OUTW     = 12;
   localparam int CHW      = 3;
   localparam int NSLOT    = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cen, zero, op_valid, pcm_en, limiter_en;
   logic [OPW-1:0]  op_result, pcm;
   logic [CHW-1:0]  ch;
   logic [1:0]      rl;
   logic [OUTW-1:0] left, right;
   logic            sample, clip, mux_sample;
   logic [OPW-1:0]  mux_left, mux_right;
   logic [CHW-1:0]  mux_ch;

   jt12_mixer #(.CHANNELS(CHANNELS), .OPW(OPW), .OUTW(OUTW), .CHW(CHW)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero),
      .op_result(op_result), .op_valid(op_valid), .ch(ch), .rl(rl),
      .pcm_en(pcm_en), .pcm(pcm), .limiter_en(limiter_en),
      .left(left), .right(right), .sample(sample), .clip(clip),
      .mux_left(mux_left), .mux_right(mux_right), .mux_ch(mux_ch),
      .mux_sample(mux_sample)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Frame-level model: plain integer sums, no bit widths except at conversion.
   typedef struct {int c; int l; int r;} mux_t;
   mux_t mq[$];
   int m_acc_l, m_acc_r;
   int m_chl [CHANNELS];
   int m_chr [CHANNELS];
   int m_rl  [CHANNELS];
   int e_left, e_right, e_clip, e_sample, e_msample, e_mch, e_ml, e_mr;

   int fv [NSLOT];
   int fch[NSLOT];
   int frl[NSLOT];
   int fo [NSLOT];

   function automatic int wrapw(int v, int w);
      int m;
      m = v & ((1 << w) - 1);
      if (m >= (1 << (w-1))) m -= (1 << w);
      return m;
   endfunction

   function automatic int conv(int v, int lim, int w);
      int hi, lo;
      hi = (1 << (w-1)) - 1;
      lo = -(1 << (w-1));
      if (lim != 0) return (v > hi) ? hi : ((v < lo) ? lo : v);
      return wrapw(v, w);
   endfunction

   function automatic int ovf(int v, int w);
      return ((v > (1 << (w-1)) - 1) || (v < -(1 << (w-1)))) ? 1 : 0;
   endfunction

   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc_l = 0; m_acc_r = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         m_chl[k] = 0; m_chr[k] = 0; m_rl[k] = 0;
      end
      mq.delete();
      e_left = 0; e_right = 0; e_clip = 0; e_sample = 0;
      e_msample = 0; e_mch = 0; e_ml = 0; e_mr = 0;
   endtask

   task automatic model_edge(bit c, bit z, bit v, int chn, int rlv, int op,
                             bit pen, int pv, bit lim);
      e_sample  = 0;
      e_msample = 0;
      if (c) begin
         if (z) begin
            e_left   = conv(m_acc_l, lim, OUTW);
            e_right  = conv(m_acc_r, lim, OUTW);
            e_clip   = ovf(m_acc_l, OUTW) | ovf(m_acc_r, OUTW);
            e_sample = 1;
            mq.delete();
            for (int k = 0; k < CHANNELS; k++)
               mq.push_back('{k, conv(wrapw(m_chl[k], OPW+3), lim, OPW),
                                 conv(wrapw(m_chr[k], OPW+3), lim, OPW)});
            m_acc_l = 0; m_acc_r = 0;
            for (int k = 0; k < CHANNELS; k++) begin
               m_chl[k] = 0; m_chr[k] = 0;
            end
            if (pen && ((m_rl[CHANNELS-1] & 2) != 0)) begin
               m_acc_l += pv; m_chl[CHANNELS-1] += pv;
            end
            if (pen && ((m_rl[CHANNELS-1] & 1) != 0)) begin
               m_acc_r += pv; m_chr[CHANNELS-1] += pv;
            end
         end else if (mq.size() > 0) begin
            mux_t e;
            e = mq.pop_front();
            e_msample = 1; e_mch = e.c; e_ml = e.l; e_mr = e.r;
         end
         if (v && (chn < CHANNELS)) begin
            if (!(pen && (chn == CHANNELS-1))) begin
               if ((rlv & 2) != 0) begin m_acc_l += op; m_chl[chn] += op; end
               if ((rlv & 1) != 0) begin m_acc_r += op; m_chr[chn] += op; end
            end
            m_rl[chn] = rlv;
         end
      end
   endtask

   task automatic check_outputs();
      chk("sample",     int'(sample),             e_sample);
      chk("mux_sample", int'(mux_sample),         e_msample);
      chk("left",       int'($signed(left)),      e_left);
      chk("right",      int'($signed(right)),     e_right);
      chk("clip",       int'(clip),               e_clip);
      chk("mux_ch",     int'(mux_ch),             e_mch);
      chk("mux_left",   int'($signed(mux_left)),  e_ml);
      chk("mux_right",  int'($signed(mux_right)), e_mr);
   endtask

   task automatic step(bit c, bit z, bit v, int chn, int rlv, int op,
                       bit pen, int pv, bit lim);
      cen = c; zero = z; op_valid = v; ch = CHW'(chn); rl = 2'(rlv);
      op_result = OPW'(op); pcm_en = pen; pcm = OPW'(pv); limiter_en = lim;
      @(posedge clk);
      model_edge(c, z, v, chn, rlv, op, pen, pv, lim);
      #1;
      check_outputs();
   endtask

   task automatic clear_frame();
      for (int i = 0; i < NSLOT; i++) begin
         fv[i] = 0; fch[i] = i % CHANNELS; frl[i] = 3; fo[i] = 0;
      end
   endtask

   task automatic run_frame(int n, bit lim, bit pen, int pv, bit tog);
      for (int i = 0; i < n; i++) begin
         step(1'b1, i == 0, fv[i] != 0, fch[i], frl[i], fo[i], pen, pv, lim);
         if (tog)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 511)) - 256, pen, pv, lim);
      end
   endtask

   initial begin
      cen = 0; zero = 0; op_valid = 0; ch = '0; rl = '0; op_result = '0;
      pcm_en = 0; pcm = '0; limiter_en = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;

      // Single ch0 carrier of +100 in a 24-slot frame.
      clear_frame(); fv[6] = 1; fo[6] = 100;
      run_frame(24, 1'b1, 1'b0, 0, 1'b0);
      // Every slot a +255 carrier: 6120 saturates, then wraps to 2024.
      clear_frame();
      for (int i = 0; i < 24; i++) begin fv[i] = 1; fo[i] = 255; end
      run_frame(24, 1'b1, 1'b0, 0, 1'b0);
      run_frame(24, 1'b1, 1'b0, 0, 1'b0);
      run_frame(24, 1'b0, 1'b0, 0, 1'b0);
      // Panning: ch1 left only, ch2 right only.
      clear_frame(); fv[1] = 1; fo[1] = -50; frl[1] = 2; fv[2] = 1; fo[2] = 30; frl[2] = 1;
      run_frame(24, 1'b0, 1'b0, 0, 1'b0);
      // PCM replaces ch5.
      clear_frame();
      for (int i = 0; i < 24; i++) if (fch[i] == 5) begin fv[i] = 1; fo[i] = 100; end
      run_frame(24, 1'b1, 1'b1, -200, 1'b0);
      run_frame(24, 1'b1, 1'b1, -200, 1'b0);
      // Carrier on the boundary slot lands in the new frame.
      clear_frame(); fv[0] = 1; fo[0] = 7;
      run_frame(24, 1'b1, 1'b0, 0, 1'b0);
      clear_frame();
      run_frame(24, 1'b1, 1'b0, 0, 1'b0);
      // Gated clock with a boundary landing mid-serialisation at k=3.
      clear_frame();
      for (int i = 0; i < 24; i++) begin fv[i] = 1; fo[i] = 10 * i - 40; end
      run_frame(4, 1'b1, 1'b0, 0, 1'b1);
      run_frame(24, 1'b1, 1'b0, 0, 1'b1);
      run_frame(24, 1'b0, 1'b0, 0, 1'b0);

      // Asynchronous reset in the middle of a frame.
      clear_frame();
      for (int i = 0; i < 24; i++) begin fv[i] = 1; fo[i] = 33; end
      for (int i = 0; i < 10; i++)
         step(1'b1, i == 0, 1'b1, fch[i], frl[i], fo[i], 1'b0, 0, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
      for (int i = 10; i < 24; i++)
         step(1'b1, 1'b0, 1'b1, fch[i], frl[i], fo[i], 1'b0, 0, 1'b1);
      clear_frame();
      run_frame(24, 1'b1, 1'b0, 0, 1'b0);

      // Randomized frames.
      repeat (30) begin
         for (int i = 0; i < NSLOT; i++) begin
            fv[i]  = int'($urandom_range(0, 1));
            fch[i] = int'($urandom_range(0, 7));
            frl[i] = int'($urandom_range(0, 3));
            fo[i]  = int'($urandom_range(0, 511)) - 256;
         end
         run_frame(24, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 511)) - 256, ($urandom_range(0, 3) == 0));
      end
      clear_frame();
      run_frame(24, 1'b1, 1'b0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
